output_edit_sequencer: RTL and testbench
========================================

OUTPUT_EDIT_SEQUENCER -- requirements
Module: output_edit_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning edit-command FIFO depth (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning bit-address width of the 32-bit output buffer.
REQ-003 SHALL have port clk  input  1  the single clock for the block.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a transaction; sampled only in IDLE.
REQ-006 SHALL have port cmd_valid  input  1  edit command present.
REQ-007 SHALL have port cmd_ready  output  1  FIFO can accept a command.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  target bit index.
REQ-009 SHALL have port cmd_val  input  1  bit value to write.
REQ-010 SHALL have port cmd_cond  input  1  write-condition flag.
REQ-011 SHALL have port cmd_last  input  1  final command of the transaction.
REQ-012 SHALL have port addr  output  ADDR_W  bit address to the output buffer.
REQ-013 SHALL have port do_write  output  1  write condition to the output buffer.
REQ-014 SHALL have port val  output  1  bit value to the output buffer.
REQ-015 SHALL have port en_edit  output  1  single-bit edit enable.
REQ-016 SHALL have port en_load_input  output  1  full-word load enable.
REQ-017 SHALL have port mux_data  output  1  select input data (1) or val (0).
REQ-018 SHALL have port busy  output  1  high in any state except IDLE.
REQ-019 SHALL have port done  output  1  one-cycle transaction-complete pulse.

Function
REQ-020 SHALL implement the states IDLE, LOAD, EDIT and DONE.
REQ-021 SHALL move IDLE->LOAD on start; start in any other state is ignored.
REQ-022 SHALL, in LOAD, assert en_load_input=1 and mux_data=1 for exactly one cycle, then move to EDIT.
REQ-023 SHALL, in EDIT with the FIFO non-empty, pop one entry per cycle and drive en_edit=1, mux_data=0, addr=head.addr, val=head.val, do_write=head.cond.
REQ-024 SHALL, in EDIT with the FIFO empty, drive en_edit=0 and stall in EDIT.
REQ-025 SHALL move EDIT->DONE on the cycle after popping an entry with last=1.
REQ-026 SHALL assert done=1 for one cycle in DONE, then return to IDLE.
REQ-027 SHALL hold en_edit, en_load_input and mux_data at 0 in IDLE and DONE, with addr, val and do_write also 0.
REQ-028 SHALL decode all outputs from the state register and FIFO head only, with no combinational path from input ports to outputs.
REQ-029 SHALL accept commands in any state; cmd_ready = !full, with a push when cmd_valid && cmd_ready.
REQ-030 SHALL, when full, keep cmd_ready low even if a pop occurs in the same cycle (no bypass).
REQ-031 SHALL allow simultaneous push and pop when not full, leaving the count unchanged.
REQ-032 SHALL wrap the FIFO pointers modulo DEPTH.
REQ-033 SHALL give a latency of: start in cycle N -> LOAD in N+1 -> first edit in N+2 if an entry is queued.

Reset
REQ-034 SHALL, on reset, go to IDLE, flush the FIFO, drive all outputs to 0 and set cmd_ready=1.
REQ-035 SHALL let reset asserted mid-transaction abort it without a done pulse, discarding queued commands.

Configuration
REQ-036 SHALL, with OUTPUT_SEQ_STATS_EN defined, add output port edit_count [5:0]: cleared on an accepted start, incremented per popped entry with cond=1, saturating at 63, reset to 0.
REQ-037 SHALL, without OUTPUT_SEQ_STATS_EN, omit the edit_count port and its logic entirely.

Structure
REQ-038 SHALL place the state enum, ADDR_W and the command struct {addr, val, cond, last} in the shared package output_seq_pkg.
REQ-039 SHALL implement the FIFO as sub-module cmd_fifo (parameter DEPTH; push/pop/full/empty/head).

Verification
REQ-040 SHALL verify: queue (3,1,1,0),(7,0,1,1) then start -> LOAD at N+1, edits addr 3 then 7 at N+2 and N+3, done at N+4.
REQ-041 SHALL verify: start with an empty FIFO, then push (0,1,1,1) 5 cycles later -> EDIT stalls with en_edit=0, edits on the cycle after the push, then done.
REQ-042 SHALL verify: push 4 entries with DEPTH=4 -> cmd_ready=0; a pop and push in the same cycle are refused.
REQ-043 SHALL verify: assert reset during EDIT with 2 entries queued -> IDLE next cycle, FIFO empty, no done pulse.
REQ-044 SHALL verify: pulse start while busy -> ignored, with the sequence unchanged.
REQ-045 SHALL verify, with OUTPUT_SEQ_STATS_EN defined: 70 entries with cond=1 -> edit_count=63, cleared to 0 by the next start.

Source files
------------

// File: rtl/output_seq_pkg.sv
// output_seq_pkg: shared state encoding, address width and edit-command record
package output_seq_pkg;
   localparam int ADDR_W = 5;
   typedef enum logic [1:0] {IDLE, LOAD, EDIT, DONE} state_t;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              val;
      logic              cond;
      logic              last;
   } cmd_t;
endpackage

// File: rtl/output_edit_sequencer_cmd_fifo.sv
// cmd_fifo: edit-command FIFO, DEPTH entries (power of two), registered head
// Ports: clk, reset (sync, active-high), push/din write side, pop read side,
//        full/empty status, head = oldest entry (valid while !empty)
module cmd_fifo import output_seq_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  cmd_t din,
   input  logic pop,
   output logic full,
   output logic empty,
   output cmd_t head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   cmd_t           mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           wr_en, rd_en;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign head  = mem[rd_ptr];
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end
endmodule

// File: rtl/output_edit_sequencer.sv
// output_edit_sequencer: loads the output word, then applies queued bit edits
// Ports: clk, reset (sync, active-high); start begins a transaction in IDLE;
//        cmd_* with cmd_valid/cmd_ready queue edit commands at any time;
//        addr/val/do_write/en_edit/en_load_input/mux_data drive the output
//        buffer; busy is high outside IDLE; done pulses once per transaction.
// Build option: OUTPUT_SEQ_STATS_EN adds edit_count[5:0], a saturating count
//        of conditional edits since the last accepted start.
module output_edit_sequencer import output_seq_pkg::*; #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = output_seq_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_val,
   input  logic              cmd_cond,
   input  logic              cmd_last,
   output logic [ADDR_W-1:0] addr,
   output logic              do_write,
   output logic              val,
   output logic              en_edit,
   output logic              en_load_input,
   output logic              mux_data,
   output logic              busy,
`ifdef OUTPUT_SEQ_STATS_EN
   output logic [5:0]        edit_count,
`endif
   output logic              done
);
   localparam int PW = output_seq_pkg::ADDR_W;
   state_t state, nxt;
   cmd_t   din, head;
   logic   full, empty, push, pop;
   assign din  = '{addr: PW'(cmd_addr), val: cmd_val, cond: cmd_cond, last: cmd_last};
   assign push = cmd_valid && !full;
   assign pop  = state == EDIT && !empty;
   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );
   always_ff @(posedge clk)
      state <= reset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? LOAD : IDLE;
         LOAD:    nxt = EDIT;
         EDIT:    nxt = (pop && head.last) ? DONE : EDIT;
         default: nxt = IDLE;
      endcase
   end
   // outputs depend only on state and the registered FIFO head/status
   always_comb begin
      cmd_ready     = !full;
      busy          = state != IDLE;
      done          = state == DONE;
      en_load_input = state == LOAD;
      mux_data      = state == LOAD;
      en_edit       = pop;
      addr          = pop ? ADDR_W'(head.addr) : '0;
      val           = pop && head.val;
      do_write      = pop && head.cond;
   end
`ifdef OUTPUT_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (reset || (state == IDLE && start)) edit_count <= '0;
      else if (pop && head.cond && edit_count != 6'd63) edit_count <= edit_count + 6'd1;
   end
`endif
endmodule

// File: tb/tb_output_edit_sequencer.sv
// tb_output_edit_sequencer: scoreboard bench for output_edit_sequencer
module tb_output_edit_sequencer;
   logic       clk = 0, reset = 1, start = 0, cmd_valid = 0;
   logic [4:0] cmd_addr = 0;
   logic       cmd_val = 0, cmd_cond = 0, cmd_last = 0;
   logic       cmd_ready, do_write, val, en_edit, en_load_input, mux_data, busy, done;
   logic [4:0] addr;
`ifdef OUTPUT_SEQ_STATS_EN
   logic [5:0] edit_count;
`endif
   int         total = 0, bad = 0, done_cnt = 0, d0;
   logic [7:0] exp_q[$];
   logic [7:0] e_mon;

   output_edit_sequencer #(.DEPTH(4), .ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_val(cmd_val), .cmd_cond(cmd_cond), .cmd_last(cmd_last),
      .addr(addr), .do_write(do_write), .val(val), .en_edit(en_edit),
      .en_load_input(en_load_input), .mux_data(mux_data), .busy(busy),
`ifdef OUTPUT_SEQ_STATS_EN
      .edit_count(edit_count),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [4:0] a, input logic v, input logic c, input logic l);
      int n = 0;
      cmd_valid = 1; cmd_addr = a; cmd_val = v; cmd_cond = c; cmd_last = l;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) check("push_timeout", 0, 1);
      else exp_q.push_back({a, v, c, l});
      tick();
      cmd_valid = 0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", done, 1);
   endtask

   // start on an empty FIFO must stall; one last entry then finishes it
   task automatic empty_check(input logic [4:0] a);
      start = 1;
      tick();
      start = 0;
      tick();
      check("fifo_empty", en_edit, 0);
      push(a, 0, 1, 1);
      check("empty_edit", en_edit, 1);
      tick();
      check("empty_done", done, 1);
      tick();
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (en_edit) begin
         if (exp_q.size() == 0) check("edit_unexpected", 1, 0);
         else begin
            e_mon = exp_q.pop_front();
            check("edit_addr", addr, e_mon[7:3]);
            check("edit_val", val, e_mon[2]);
            check("edit_wr", do_write, e_mon[1]);
            check("edit_mux", mux_data, 0);
            check("edit_load", en_load_input, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      reset = 0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", cmd_ready, 1);
      check("rst_edit", en_edit, 0);
      check("rst_load", en_load_input, 0);
      check("rst_mux", mux_data, 0);
      check("rst_out", {addr, val, do_write}, 0);
`ifdef OUTPUT_SEQ_STATS_EN
      check("rst_ec", edit_count, 0);
`endif
      // basic two-edit transaction and latency
      push(3, 1, 1, 0);
      push(7, 0, 1, 1);
      start = 1;
      tick();
      start = 0;
      check("t1_load", en_load_input, 1);
      check("t1_load_mux", mux_data, 1);
      check("t1_load_busy", busy, 1);
      check("t1_load_edit", en_edit, 0);
      tick();
      check("t1_edit0", en_edit, 1);
      tick();
      check("t1_edit1", en_edit, 1);
      tick();
      check("t1_done", done, 1);
      tick();
      check("t1_idle", busy, 0);
      check("t1_done_pulse", done, 0);
      // stall on empty FIFO
      start = 1;
      tick();
      start = 0;
      tick();
      for (int i = 0; i < 4; i++) begin
         check("t2_stall", en_edit, 0);
         check("t2_busy", busy, 1);
         tick();
      end
      push(0, 1, 1, 1);
      check("t2_edit", en_edit, 1);
      tick();
      check("t2_done", done, 1);
      tick();
      // full FIFO, no bypass on pop
      push(1, 1, 1, 0);
      push(2, 0, 0, 0);
      push(5, 1, 0, 0);
      push(9, 1, 1, 1);
      check("t3_full", cmd_ready, 0);
      start = 1;
      tick();
      start = 0;
      check("t3_full_load", cmd_ready, 0);
      tick();
      check("t3_pop", en_edit, 1);
      check("t3_nobypass", cmd_ready, 0);
      cmd_valid = 1; cmd_addr = 31; cmd_val = 1; cmd_cond = 1; cmd_last = 1;
      tick();
      cmd_valid = 0;
      check("t3_ready_after", cmd_ready, 1);
      tick();
      tick();
      tick();
      check("t3_done", done, 1);
      tick();
      empty_check(4);
      // reset mid-transaction
      push(10, 1, 1, 0);
      push(11, 0, 0, 0);
      push(12, 1, 1, 1);
      start = 1;
      tick();
      start = 0;
      tick();
      check("t4_edit", en_edit, 1);
      reset = 1;
      d0 = done_cnt;
      tick();
      reset = 0;
      exp_q.delete();
      check("t4_idle", busy, 0);
      check("t4_no_edit", en_edit, 0);
      check("t4_ready", cmd_ready, 1);
      for (int i = 0; i < 3; i++) tick();
      check("t4_nodone", done_cnt, d0);
      empty_check(13);
      // start while busy is ignored
      push(6, 1, 0, 0);
      push(8, 0, 1, 1);
      start = 1;
      tick();
      check("t5_load", en_load_input, 1);
      tick();
      check("t5_edit0", en_edit, 1);
      tick();
      check("t5_edit1", en_edit, 1);
      tick();
      check("t5_done", done, 1);
      tick();
      start = 0;
      check("t5_idle", busy, 0);
      tick();
      check("t5_still_idle", busy, 0);
`ifdef OUTPUT_SEQ_STATS_EN
      start = 1;
      tick();
      start = 0;
      check("ec_clear0", edit_count, 0);
      for (int i = 0; i < 70; i++) push(5'(i), 1, 1, i == 69);
      wait_done(200);
      check("ec_sat", edit_count, 63);
      tick();
      start = 1;
      tick();
      start = 0;
      check("ec_clear", edit_count, 0);
      push(1, 1, 1, 1);
      wait_done(20);
      tick();
`endif
      check("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
